// File: rtl/pipe_defs.sv
// Shared pipeline definitions: hazard FSM states and
// the control bundles that stall, flush or bubble the front end.
package pipe_defs;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
  } hz_ctrl_t;

  // ifid_flush loads a NOP; idex_bubble loads zero control/funct
  localparam hz_ctrl_t CTL_RESET    = 5'b00001;
  localparam hz_ctrl_t CTL_RUN      = 5'b11010;
  localparam hz_ctrl_t CTL_LOAD_USE = 5'b00011;
  localparam hz_ctrl_t CTL_FLUSH    = 5'b11111;
  localparam hz_ctrl_t CTL_FREEZE   = 5'b00000;
  localparam hz_ctrl_t CTL_ABORT    = 5'b11011;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: a load in ID/EX feeds a source
// register of the instruction sitting in ID.
module hazard_cmp (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hit
);

  assign hit = ex_valid & ex_mem_read
             & (ex_rd != 5'd0) & id_valid
             & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch flush, multi-cycle wait.
// Define PIPE_HAZARD_PERF_EN to build the stall/flush perf counters.
import pipe_defs::*;

module pipe_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_multi,
  input  logic             ex_multi_done,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = $clog2(MC_TIMEOUT) + 1;

  hz_state_t     state_q, state_d;
  hz_ctrl_t      ctl;
  logic [TW-1:0] tcnt_q;
  logic          lu_hit, br, mc_stall, tmo;

  hazard_cmp u_cmp (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hit         (lu_hit)
  );

  assign br       = branch_taken & ex_valid;
  assign mc_stall = ex_valid & ex_multi & ~ex_multi_done;
  assign tmo      = (tcnt_q == TW'(MC_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // cleared while in RUN so it reads 0 on the first wait cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tcnt_q <= '0;
    else if (state_q == RUN) tcnt_q <= '0;
    else                     tcnt_q <= tcnt_q + TW'(1);
  end

  always_comb begin
    ctl     = CTL_RUN;
    state_d = state_q;
    mc_err  = 1'b0;
    if (!rst_n) begin
      ctl     = CTL_RESET;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (br) begin
            ctl = CTL_FLUSH;
          end else if (mc_stall) begin
            ctl     = CTL_FREEZE;
            state_d = MC_WAIT;
          end else if (lu_hit) begin
            ctl = CTL_LOAD_USE;
          end
        end
        MC_WAIT: begin
          if (ex_multi_done) begin
            state_d = RUN;
          end else if (tmo) begin
            ctl     = CTL_ABORT;
            mc_err  = 1'b1;
            state_d = RUN;
          end else begin
            ctl = CTL_FREEZE;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign {pc_en, ifid_en, ifid_flush,
          idex_en, idex_bubble} = ctl;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int TMO  = 8;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid, ex_valid, ex_mem_read;
  logic          ex_multi, ex_multi_done, branch_taken;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          pc_en, ifid_en, ifid_flush;
  logic          idex_en, idex_bubble, mc_err;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [5:0]    obs;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit         m_wait;
  int         m_waited;
  int         m_stall, m_flush;
  logic [5:0] exp_vec;
  int         exp_stall, exp_flush;

  pipe_hazard_ctrl #(.MC_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_multi      (ex_multi),
    .ex_multi_done (ex_multi_done),
    .branch_taken  (branch_taken),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_en       (idex_en),
    .idex_bubble   (idex_bubble),
    .mc_err        (mc_err),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  assign obs = {pc_en, ifid_en, ifid_flush,
                idex_en, idex_bubble, mc_err};

  always #5 clk = ~clk;

  // vec order: pc_en ifid_en ifid_flush idex_en idex_bubble mc_err
  task automatic model_eval();
    bit lu;
    lu = ex_valid && ex_mem_read && ex_rd != 0 && id_valid
         && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (!rst_n)                               exp_vec = 6'b000010;
    else if (!m_wait) begin
      if (branch_taken && ex_valid)           exp_vec = 6'b111110;
      else if (ex_valid && ex_multi && !ex_multi_done)
                                              exp_vec = 6'b000000;
      else if (lu)                            exp_vec = 6'b000110;
      else                                    exp_vec = 6'b110100;
    end else begin
      if (ex_multi_done)                      exp_vec = 6'b110100;
      else if (m_waited == TMO - 1)           exp_vec = 6'b110111;
      else                                    exp_vec = 6'b000000;
    end
`ifdef PIPE_HAZARD_PERF_EN
    exp_stall = rst_n ? m_stall : 0;
    exp_flush = rst_n ? m_flush : 0;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
  endtask

  task automatic model_adv();
    if (!rst_n) begin
      m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!exp_vec[5] && m_stall < MAXC) m_stall++;
    if (exp_vec[3] && m_flush < MAXC)  m_flush++;
    if (!m_wait) begin
      m_wait = ex_valid && ex_multi && !ex_multi_done
               && !(branch_taken && ex_valid);
      m_waited = 0;
    end else if (ex_multi_done || m_waited == TMO - 1) begin
      m_wait = 0;
    end else begin
      m_waited++;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_mem_read = 0;
    ex_multi = 0; ex_multi_done = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    settle();
    checks++;
    if (obs !== 6'b000010 || obs !== exp_vec) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=%b", obs, 6'b000010);
    end
    checks++;
    if (stall_cycles !== 0 || flush_count !== 0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0",
               stall_cycles, flush_count);
    end
    tick(); tick();
    rst_n = 1;
    settle();
    checks++;
    if (obs !== 6'b110100 || obs !== exp_vec) begin
      failures++;
      $display("FAIL run_default got=%b want=%b", obs, 6'b110100);
    end
    tick();
  endtask

  task automatic test_load_use();
    int nstall = 0;
    idle();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd5;
    ex_valid = 1; ex_rd = 5'd5; ex_mem_read = 1;
    settle();
    checks++;
    if (obs !== 6'b000110 || obs !== exp_vec) begin
      failures++;
      $display("FAIL load_use got=%b want=%b", obs, 6'b000110);
    end
    if (!pc_en) nstall++;
    tick();
    ex_valid = 0; ex_mem_read = 0;
    settle();
    checks++;
    if (obs !== exp_vec) begin
      failures++;
      $display("FAIL load_use_after got=%b want=%b", obs, exp_vec);
    end
    if (!pc_en) nstall++;
    checks++;
    if (nstall != 1) begin
      failures++;
      $display("FAIL load_use_len got=%0d want=1", nstall);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    idle();
    id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd9;
    ex_valid = 1; ex_rd = 5'd0; ex_mem_read = 1;
    settle();
    checks++;
    if (obs !== 6'b110100 || obs !== exp_vec) begin
      failures++;
      $display("FAIL x0_no_stall got=%b want=%b", obs, 6'b110100);
    end
    tick();
    id_rs1 = 5'd4; id_rs2 = 5'd6; ex_rd = 5'd3;
    settle();
    checks++;
    if (obs !== 6'b110100 || obs !== exp_vec) begin
      failures++;
      $display("FAIL no_match got=%b want=%b", obs, 6'b110100);
    end
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    int f0;
    idle();
    id_valid = 1; id_rs1 = 5'd7; id_rs2 = 5'd2;
    ex_valid = 1; ex_rd = 5'd7; ex_mem_read = 1;
    branch_taken = 1;
    settle();
    f0 = exp_flush;
    checks++;
    if (obs !== 6'b111110 || obs !== exp_vec) begin
      failures++;
      $display("FAIL branch_pri got=%b want=%b", obs, 6'b111110);
    end
    tick();
    idle();
    settle();
    checks++;
`ifdef PIPE_HAZARD_PERF_EN
    if (flush_count !== CW'(f0 + 1) || int'(flush_count) != exp_flush) begin
      failures++;
      $display("FAIL flush_cnt got=%0d want=%0d", flush_count, f0 + 1);
    end
`else
    if (flush_count !== 0 || exp_flush != f0) begin
      failures++;
      $display("FAIL flush_cnt got=%0d want=0", flush_count);
    end
`endif
    tick();
  endtask

  task automatic test_multi();
    int frozen = 0;
    int s0;
    idle();
    settle();
    s0 = exp_stall;
    ex_valid = 1; ex_multi = 1;
    for (int i = 0; i <= 4; i++) begin
      ex_multi_done = (i == 4);
      settle();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("FAIL multi_c%0d got=%b want=%b", i, obs, exp_vec);
      end
      if (!pc_en) frozen++;
      tick();
    end
    idle();
    settle();
    checks++;
    if (frozen != 4 || obs !== 6'b110100) begin
      failures++;
      $display("FAIL multi_len got=%0d/%b want=4/%b",
               frozen, obs, 6'b110100);
    end
    checks++;
`ifdef PIPE_HAZARD_PERF_EN
    if (stall_cycles !== CW'(s0 + 4)) begin
      failures++;
      $display("FAIL multi_stall_cnt got=%0d want=%0d",
               stall_cycles, s0 + 4);
    end
`else
    if (stall_cycles !== 0 || s0 != 0) begin
      failures++;
      $display("FAIL multi_stall_cnt got=%0d want=0", stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_timeout();
    int err_at = -1;
    int npulse = 0;
    idle();
    ex_valid = 1; ex_multi = 1;
    for (int i = 0; i <= TMO; i++) begin
      settle();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("FAIL tmo_c%0d got=%b want=%b", i, obs, exp_vec);
      end
      if (mc_err) begin
        npulse++;
        err_at = i;
      end
      tick();
    end
    checks++;
    if (err_at != TMO || npulse != 1) begin
      failures++;
      $display("FAIL tmo_pulse got=c%0d x%0d want=c%0d x1",
               err_at, npulse, TMO);
    end
    idle();
    settle();
    checks++;
    if (obs !== 6'b110100) begin
      failures++;
      $display("FAIL tmo_run got=%b want=%b", obs, 6'b110100);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle();
    ex_valid = 1; ex_multi = 1;
    settle(); tick();
    settle(); tick();
    rst_n = 0;
    settle();
    checks++;
    if (obs !== 6'b000010 || stall_cycles !== 0 || flush_count !== 0) begin
      failures++;
      $display("FAIL rst_mid_wait got=%b/%0d/%0d want=%b/0/0",
               obs, stall_cycles, flush_count, 6'b000010);
    end
    tick();
    idle();
    rst_n = 1;
    settle();
    checks++;
    if (obs !== 6'b110100 || obs !== exp_vec) begin
      failures++;
      $display("FAIL rst_release got=%b want=%b", obs, 6'b110100);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst_n         = ($urandom_range(0, 399) != 0);
      id_valid      = ($urandom_range(0, 9) != 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_valid      = ($urandom_range(0, 9) != 0);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_mem_read   = $urandom_range(0, 1) == 1;
      ex_multi      = ($urandom_range(0, 5) == 0);
      ex_multi_done = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      settle();
      checks++;
      if (obs !== exp_vec) begin
        failures++;
        $display("FAIL rnd_ctl n=%0d got=%b want=%b", n, obs, exp_vec);
      end
      checks++;
      if (int'(stall_cycles) != exp_stall
          || int'(flush_count) != exp_flush) begin
        failures++;
        $display("FAIL rnd_cnt n=%0d got=%0d/%0d want=%0d/%0d",
                 n, stall_cycles, flush_count, exp_stall, exp_flush);
      end
      tick();
    end
  endtask

  initial begin
    m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_vs_load_use();
    test_multi();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MC_TIMEOUT, default 64, giving the maximum cycles spent in MC_WAIT before abort.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 Ports SHALL be, one per line as: name  direction  width  meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- ex_valid  in  1  ID/EX register holds a valid instruction.
- ex_rd  in  5  ID/EX destination register.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_multi  in  1  ID/EX instruction is a multi-cycle op.
- ex_multi_done  in  1  multi-cycle unit result ready.
- branch_taken  in  1  branch resolved taken in EX.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX write enable.
- idex_bubble  out  1  ID/EX loads zero control and zero funct.
- mc_err  out  1  one-cycle pulse on multi-cycle timeout.
- stall_cycles  out  CNT_W  stall-cycle counter.
- flush_count  out  CNT_W  flush-event counter.

Function
REQ-004 The FSM SHALL have exactly two states, RUN and MC_WAIT; control outputs SHALL be combinational from state and inputs.
REQ-005 Default in RUN SHALL be: pc_en=ifid_en=idex_en=1, ifid_flush=idex_bubble=0.
REQ-006 Load-use hazard SHALL be detected as: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-007 On load-use in RUN, the block SHALL drive pc_en=0, ifid_en=0, idex_bubble=1 for that cycle only, and stay in RUN.
REQ-008 On branch_taken & ex_valid in RUN, the block SHALL drive ifid_flush=1 and idex_bubble=1 with pc_en=1, and load-use SHALL be ignored that cycle.
REQ-009 On ex_valid & ex_multi & ~ex_multi_done in RUN with no taken branch, the block SHALL drive pc_en=ifid_en=idex_en=0 and enter MC_WAIT next cycle.
REQ-010 A multi-cycle op with ex_multi_done=1 in its first cycle SHALL cause no stall.
REQ-011 In MC_WAIT, pc_en, ifid_en and idex_en SHALL be 0 until ex_multi_done=1.
REQ-012 On the cycle ex_multi_done=1 in MC_WAIT, enables SHALL be 1 and the FSM SHALL return to RUN.
REQ-013 branch_taken SHALL be ignored in MC_WAIT.
REQ-014 A timeout counter SHALL clear on MC_WAIT entry and increment each MC_WAIT cycle.
REQ-015 When the timeout counter reaches MC_TIMEOUT-1 without done, the block SHALL pulse mc_err, drive enables=1 with idex_bubble=1 that cycle, and return to RUN.
REQ-016 Priority SHALL be: taken branch > multi-cycle stall > load-use.

Reset
REQ-017 While rst_n=0, the FSM SHALL be RUN, counters SHALL be 0, pc_en=ifid_en=idex_en=0, idex_bubble=1, and ifid_flush=mc_err=0.
REQ-018 Reset asserted mid-MC_WAIT SHALL abort immediately without an mc_err pulse.

Configuration
REQ-019 With macro PIPE_HAZARD_PERF_EN defined, stall_cycles SHALL increment on every cycle with pc_en=0 (reset deasserted), and flush_count SHALL increment on every ifid_flush=1.
REQ-020 With PIPE_HAZARD_PERF_EN defined, both counters SHALL saturate at all-ones.
REQ-021 Without PIPE_HAZARD_PERF_EN, both counter outputs SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-022 State encodings and the NOP/bubble constants SHALL live in the shared pipeline definitions package, pipe_defs.
REQ-023 The load-use comparator SHALL be a sub-module named hazard_cmp.

Verification
REQ-024 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, both valid -> exactly one cycle of pc_en=0 and idex_bubble=1.
REQ-025 x0 and no hazard: ex_rd=0 with id_rs1=0 -> no stall; ex_rd=3 with rs1=4, rs2=6 -> no stall.
REQ-026 Branch vs load-use: branch_taken=1 in the same cycle as a load-use match -> ifid_flush=1, pc_en=1, flush_count +1.
REQ-027 Multi-cycle: ex_multi=1 with done asserted 4 cycles later -> 4 frozen cycles, then RUN, stall_cycles=4.
REQ-028 Timeout: MC_TIMEOUT=8 with done never asserted -> mc_err pulses on the 8th cycle, bubble inserted, FSM returns to RUN.
REQ-029 Reset mid-MC_WAIT: rst_n low at cycle 2 of a wait -> outputs at reset values, no mc_err, RUN after release.
